// File: rtl/dm_port_sched.sv
// dm_port_sched: arbitrates the single data-memory port between the load pipe
// and a committed-store buffer (circular FIFO). Tracks the one outstanding
// read, returns its tag/data one cycle after dm_rvalid, and drains buffered
// stores after a flush.
// Optional: DM_LD_ST_HAZARD_EN blocks loads whose word address matches any
// buffered store until that store has been written.
module dm_port_sched #(
  parameter int SB_DEPTH     = 4,
  parameter int TAG_W        = 6,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ld_req_valid,
  output logic                      ld_req_ready,
  input  logic [31:0]               ld_req_addr,
  input  logic [TAG_W-1:0]          ld_req_tag,
  input  logic                      st_commit_valid,
  output logic                      st_commit_ready,
  input  logic [31:0]               st_commit_addr,
  input  logic [31:0]               st_commit_data,
  input  logic [1:0]                st_commit_size,
  output logic [31:0]               dm_addr,
  output logic [31:0]               dm_wdata,
  output logic [1:0]                dm_size,
  output logic                      dm_read,
  output logic                      dm_write,
  input  logic                      dm_ready,
  input  logic                      dm_rvalid,
  input  logic [31:0]               dm_rdata,
  output logic                      ld_resp_valid,
  output logic [TAG_W-1:0]          ld_resp_tag,
  output logic [31:0]               ld_resp_data,
  input  logic                      flush,
  output logic                      drain_busy,
  output logic [$clog2(SB_DEPTH):0] sb_count
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             kill_q, kill_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             resp_v_q, resp_v_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic [31:0] sb_addr_q [SB_DEPTH];
  logic [31:0] sb_data_q [SB_DEPTH];
  logic [1:0]  sb_size_q [SB_DEPTH];

  logic sb_nempty, sb_full, starved, hazard;
  logic pick_st, pick_ld, push, pop, kill_now;

  assign sb_nempty       = (count_q != '0);
  assign sb_full         = (count_q == CW'(SB_DEPTH));
  assign starved         = (starve_q >= SW'(STARVE_LIMIT));
  assign st_commit_ready = (count_q < CW'(SB_DEPTH));
  assign push            = st_commit_valid & st_commit_ready;
  assign kill_now        = kill_q | flush;

`ifdef DM_LD_ST_HAZARD_EN
  // Word-address match of the pending load against every live SB entry
  always_comb begin
    logic [PW-1:0] off;
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (sb_addr_q[i][31:2] == ld_req_addr[31:2]))
        hazard = 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Port arbitration and memory-side request drive
  always_comb begin
    pick_st = 1'b0;
    pick_ld = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A flush only suppresses loads; committed stores keep draining.
        if (sb_nempty && (flush || !ld_req_valid || sb_full || starved || hazard))
          pick_st = 1'b1;
        else if (ld_req_valid && !flush)
          pick_ld = 1'b1;
      end
      S_DRAIN: pick_st = sb_nempty;
      default: ;
    endcase
    dm_write     = pick_st;
    dm_read      = pick_ld;
    dm_addr      = pick_st ? sb_addr_q[head_q] :
                   pick_ld ? {ld_req_addr[31:2], 2'b00} : 32'h0;
    dm_wdata     = pick_st ? sb_data_q[head_q] : 32'h0;
    dm_size      = pick_st ? sb_size_q[head_q] : 2'd0;
    ld_req_ready = pick_ld & dm_ready;
    pop          = pick_st & dm_ready;
  end

  // Next-state: FSM, starvation counter, read tag and response register
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    starve_d    = starve_q;
    tag_d       = tag_q;
    resp_v_d    = 1'b0;
    resp_tag_d  = resp_tag_q;
    resp_data_d = resp_data_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = sb_nempty ? S_DRAIN : S_IDLE;
        end else if (ld_req_ready) begin
          state_d = S_RD_WAIT;
          tag_d   = ld_req_tag;
          if (sb_nempty && !starved) starve_d = starve_q + SW'(1);
        end
      end
      S_RD_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dm_rvalid) begin
          // A killed read still completes on the bus but is never returned.
          resp_v_d = ~kill_now;
          if (!kill_now) begin
            resp_tag_d  = tag_q;
            resp_data_d = dm_rdata;
          end
          kill_d  = 1'b0;
          state_d = (kill_now && sb_nempty) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: if (!sb_nempty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pop) starve_d = '0;
  end

  // Control state; reset discards any outstanding read and empties the SB
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      tag_q       <= '0;
      resp_v_q    <= 1'b0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      tag_q       <= tag_d;
      resp_v_q    <= resp_v_d;
      resp_tag_q  <= resp_tag_d;
      resp_data_q <= resp_data_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
    end
  end

  // Store buffer payload; occupancy is tracked by the pointers above
  always_ff @(posedge CLK) begin
    if (push) begin
      sb_addr_q[tail_q] <= st_commit_addr;
      sb_data_q[tail_q] <= st_commit_data;
      sb_size_q[tail_q] <= st_commit_size;
    end
  end

  assign ld_resp_valid = resp_v_q;
  assign ld_resp_tag   = resp_tag_q;
  assign ld_resp_data  = resp_data_q;
  assign drain_busy    = (state_q == S_DRAIN) | ((state_q == S_RD_WAIT) & kill_q);
  assign sb_count      = count_q;

endmodule
